// File: rtl/simd_alu_pipe.sv
// Multi-lane registered shader ALU: single-cycle ops plus a multi-cycle
// restoring divider, with valid/ready handshakes on both sides.

package simd_alu_pkg;
    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_MUL  = 4'd3,
        OP_DIV  = 4'd4,
        OP_MIN  = 4'd5,
        OP_MAX  = 4'd6,
        OP_AND  = 4'd7,
        OP_OR   = 4'd8,
        OP_XOR  = 4'd9,
        OP_XNOR = 4'd10
    } opcodes_t;
endpackage

// One lane: combinational ALU result plus one restoring-divider step per cycle.
module simd_alu_lane
    import simd_alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  opcodes_t          i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_load,
    input  logic              i_step,
    output logic [DATA_W-1:0] o_alu,
    output logic [DATA_W-1:0] o_quo_nxt
);
    logic [DATA_W-1:0] r_q;
    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_div;
    logic [DATA_W-1:0] w_sh;
    logic              w_ge;
    logic [DATA_W-1:0] w_rem_nxt;

    always_comb begin
        o_alu = '0;
        case (i_op)
            OP_ADD:  o_alu = i_a + i_b;
            OP_SUB:  o_alu = i_a - i_b;
            OP_MUL:  o_alu = i_a * i_b;
            OP_MIN:  o_alu = (i_b < i_a) ? i_b : i_a;
            OP_MAX:  o_alu = (i_b > i_a) ? i_b : i_a;
            OP_AND:  o_alu = i_a & i_b;
            OP_OR:   o_alu = i_a | i_b;
            OP_XOR:  o_alu = i_a ^ i_b;
            OP_XNOR: o_alu = ~(i_a ^ i_b);
            default: o_alu = '0;
        endcase
    end

    // The shifted-out remainder MSB stands in for the extra trial bit, so the
    // subtract stays DATA_W wide; a zero divisor always "fits" -> all-ones.
    assign w_sh      = {r_rem[DATA_W-2:0], r_q[DATA_W-1]};
    assign w_ge      = r_rem[DATA_W-1] || (w_sh >= r_div);
    assign w_rem_nxt = w_ge ? (w_sh - r_div) : w_sh;
    assign o_quo_nxt = {r_q[DATA_W-2:0], w_ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q   <= '0;
            r_rem <= '0;
            r_div <= '0;
        end else if (i_load) begin
            r_q   <= i_a;
            r_rem <= '0;
            r_div <= i_b;
        end else if (i_step) begin
            r_q   <= o_quo_nxt;
            r_rem <= w_rem_nxt;
        end
    end
endmodule

module simd_alu_pipe
    import simd_alu_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int DATA_W = 32,
    parameter int RD_W   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  opcodes_t                in_opcode,
    input  logic [RD_W-1:0]         in_rd,
    input  logic [LANES-1:0]        in_lane_mask,
    input  logic [LANES*DATA_W-1:0] in_a,
    input  logic [LANES*DATA_W-1:0] in_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [RD_W-1:0]         out_rd,
    output logic [LANES*DATA_W-1:0] out_result,
    output logic [LANES-1:0]        out_wr_mask,
    output logic                    out_illegal,
    output logic                    busy
);
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic {S_IDLE, S_DIV} state_t;

    typedef struct packed {
        logic                         valid;
        logic                         illegal;
        logic [LANES-1:0]             wr_mask;
        logic [RD_W-1:0]              rd;
        logic [LANES-1:0][DATA_W-1:0] result;
    } rsp_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [CNT_W-1:0]             r_cnt;
    logic [LANES-1:0]             r_mask;
    logic [RD_W-1:0]              r_rd;
    rsp_t                         r_rsp;

    logic [LANES-1:0][DATA_W-1:0] w_a;
    logic [LANES-1:0][DATA_W-1:0] w_b;
    logic [LANES-1:0][DATA_W-1:0] w_alu;
    logic [LANES-1:0][DATA_W-1:0] w_quo;
    logic [LANES-1:0][DATA_W-1:0] w_res_alu;
    logic [LANES-1:0][DATA_W-1:0] w_res_div;
    logic                         w_acc;
    logic                         w_is_div;
    logic                         w_legal;
    logic                         w_wr_op;
    logic                         w_div_load;
    logic                         w_div_step;
    logic                         w_div_done;

    assign w_a        = in_a;
    assign w_b        = in_b;
    assign w_acc      = in_valid && in_ready;
    assign w_is_div   = (in_opcode == OP_DIV);
    assign w_legal    = (in_opcode <= OP_XNOR);
    assign w_wr_op    = w_legal && (in_opcode != OP_NOP);
    assign w_div_load = w_acc && w_is_div;
    assign w_div_step = (r_state == S_DIV);
    assign w_div_done = w_div_step && (r_cnt == '0);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        simd_alu_lane #(.DATA_W(DATA_W)) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_op      (in_opcode),
            .i_a       (w_a[g]),
            .i_b       (w_b[g]),
            .i_load    (w_div_load),
            .i_step    (w_div_step),
            .o_alu     (w_alu[g]),
            .o_quo_nxt (w_quo[g])
        );
        assign w_res_alu[g] = (in_lane_mask[g] && w_wr_op) ? w_alu[g] : '0;
        assign w_res_div[g] = r_mask[g] ? w_quo[g] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_div_load) w_state_nxt = S_DIV;
            S_DIV:   if (w_div_done) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (r_state == S_IDLE) && (!r_rsp.valid || out_ready);
        busy     = (r_state == S_DIV);
    end

    // DIV completion cannot collide with a new accept: in_ready is low in S_DIV.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_mask <= '0;
            r_rd   <= '0;
            r_rsp  <= '0;
        end else begin
            if (w_div_load) begin
                r_cnt  <= CNT_W'(DATA_W - 1);
                r_mask <= in_lane_mask;
                r_rd   <= in_rd;
            end else if (w_div_step) begin
                r_cnt  <= r_cnt - 1'b1;
            end

            if (w_acc && !w_is_div) begin
                r_rsp <= '{valid:   1'b1,
                           illegal: !w_legal,
                           wr_mask: in_lane_mask & {LANES{w_wr_op}},
                           rd:      in_rd,
                           result:  w_res_alu};
            end else if (w_div_done) begin
                r_rsp <= '{valid:   1'b1,
                           illegal: 1'b0,
                           wr_mask: r_mask,
                           rd:      r_rd,
                           result:  w_res_div};
            end else if (out_ready) begin
                r_rsp.valid <= 1'b0;
            end
        end
    end

    assign out_valid   = r_rsp.valid;
    assign out_illegal = r_rsp.illegal;
    assign out_wr_mask = r_rsp.wr_mask;
    assign out_rd      = r_rsp.rd;
    assign out_result  = r_rsp.result;
endmodule

// File: tb/tb_simd_alu_pipe.sv
// Bench for simd_alu_pipe: vector table + random stream through a scoreboard,
// plus hand-written DIV timing, backpressure and mid-DIV reset sequences.
module tb_simd_alu_pipe;
    import simd_alu_pkg::*;

    localparam int LANES = 4, DATA_W = 32, RD_W = 4, NV = 16;

    typedef struct {
        logic [127:0] res;
        logic [3:0]   wm;
        logic         ill;
        logic [3:0]   rd;
    } exp_t;

    typedef struct {
        opcodes_t     op;
        logic [3:0]   rd;
        logic [3:0]   mask;
        logic [127:0] a;
        logic [127:0] b;
        logic [127:0] res;
        logic [3:0]   wm;
        logic         ill;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    opcodes_t     in_opcode = OP_NOP;
    logic [3:0]   in_rd = '0;
    logic [3:0]   in_lane_mask = '0;
    logic [127:0] in_a = '0;
    logic [127:0] in_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [3:0]   out_rd;
    logic [127:0] out_result;
    logic [3:0]   out_wr_mask;
    logic         out_illegal;
    logic         busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   pops = 0;
    exp_t sb[$];
    int   pop_cyc[$];
    exp_t mon_e;
    vec_t v[NV];

    simd_alu_pipe #(.LANES(LANES), .DATA_W(DATA_W), .RD_W(RD_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_lane_mask(in_lane_mask),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_rd(out_rd), .out_result(out_result), .out_wr_mask(out_wr_mask),
        .out_illegal(out_illegal), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [127:0] pk(logic [31:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [31:0] ref_lane(opcodes_t op, logic [31:0] a, b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_MUL:  return a * b;
            OP_DIV:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_MIN:  return (a <= b) ? a : b;
            OP_MAX:  return (a >= b) ? a : b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_XNOR: return ~(a ^ b);
            default: return 32'd0;
        endcase
    endfunction

    function automatic exp_t ref_req(opcodes_t op, logic [3:0] rd, mask, logic [127:0] a, b);
        exp_t e;
        logic wr;
        wr    = (op != OP_NOP) && (4'(op) <= 4'd10);
        e.res = '0;
        for (int l = 0; l < 4; l++)
            if (wr && mask[l]) e.res[l*32 +: 32] = ref_lane(op, a[l*32 +: 32], b[l*32 +: 32]);
        e.wm  = wr ? mask : 4'b0;
        e.ill = (4'(op) > 4'd10);
        e.rd  = rd;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out got rd %0d result %h want no output", out_rd, out_result);
            end else begin
                mon_e = sb.pop_front();
                chk("result", out_result, mon_e.res);
                chk("wr_mask", 128'(out_wr_mask), 128'(mon_e.wm));
                chk("illegal", 128'(out_illegal), 128'(mon_e.ill));
                chk("rd", 128'(out_rd), 128'(mon_e.rd));
            end
            pop_cyc.push_back(cyc);
            pops++;
        end
    end

    task automatic send(input opcodes_t op, input logic [3:0] rd, mask,
                        input logic [127:0] a, b, input exp_t e);
        int n;
        in_valid = 1'b1; in_opcode = op; in_rd = rd; in_lane_mask = mask; in_a = a; in_b = b;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got in_ready 0 want 1");
        end else begin
            sb.push_back(e);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 128'(sb.size()), 128'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t     e;
        int       p0, n;
        logic     ok;
        opcodes_t op;
        logic [3:0]   m;
        logic [127:0] a, b;

        v[0]  = '{OP_ADD, 4'd1, 4'hF, pk(1, 32'hFFFF_FFFF, 7, 100), pk(2, 1, 3, 50), pk(3, 0, 10, 150), 4'hF, 1'b0};
        v[1]  = '{OP_MUL, 4'd2, 4'h5, pk(3, 3, 3, 3), pk(3, 3, 3, 3), pk(9, 0, 9, 0), 4'h5, 1'b0};
        v[2]  = '{opcodes_t'(4'd12), 4'd3, 4'hF, pk(1, 2, 3, 4), pk(5, 6, 7, 8), '0, 4'h0, 1'b1};
        v[3]  = '{OP_NOP, 4'd4, 4'hF, pk(1, 2, 3, 4), pk(5, 6, 7, 8), '0, 4'h0, 1'b0};
        v[4]  = '{OP_SUB, 4'd5, 4'hF, pk(0, 10, 5, 1), pk(1, 3, 5, 0), pk(32'hFFFF_FFFF, 7, 0, 1), 4'hF, 1'b0};
        v[5]  = '{OP_AND, 4'd6, 4'hF, pk(32'hF0F0, 32'hFFFF_FFFF, 0, 12), pk(32'hFF00, 32'h1234, 5, 10), pk(32'hF000, 32'h1234, 0, 8), 4'hF, 1'b0};
        v[6]  = '{OP_OR,  4'd7, 4'hF, pk(32'hF0F0, 32'hFFFF_FFFF, 0, 12), pk(32'hFF00, 32'h1234, 5, 10), pk(32'hFFF0, 32'hFFFF_FFFF, 5, 14), 4'hF, 1'b0};
        v[7]  = '{OP_XOR, 4'd8, 4'hF, pk(32'hF0F0, 32'hFFFF_FFFF, 0, 12), pk(32'hFF00, 32'h1234, 5, 10), pk(32'h0FF0, 32'hFFFF_EDCB, 5, 6), 4'hF, 1'b0};
        v[8]  = '{OP_MIN, 4'd9, 4'hF, pk(5, 1, 9, 32'hFFFF_FFFF), pk(5, 2, 3, 0), pk(5, 1, 3, 0), 4'hF, 1'b0};
        v[9]  = '{OP_MAX, 4'd10, 4'hF, pk(5, 1, 9, 32'hFFFF_FFFF), pk(5, 2, 3, 0), pk(5, 2, 9, 32'hFFFF_FFFF), 4'hF, 1'b0};
        v[10] = '{OP_XNOR, 4'd11, 4'hF, '0, '0, {128{1'b1}}, 4'hF, 1'b0};
        v[11] = '{OP_XNOR, 4'd12, 4'hF, pk(32'hFFFF_FFFF, 0, 32'hF0F0_F0F0, 1), pk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 1), pk(32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFF), 4'hF, 1'b0};
        v[12] = '{OP_MIN, 4'd13, 4'hA, pk(1, 2, 3, 4), pk(4, 3, 2, 1), pk(0, 2, 0, 1), 4'hA, 1'b0};
        v[13] = '{OP_MAX, 4'd14, 4'hF, pk(0, 7, 7, 8), pk(0, 7, 8, 7), pk(0, 7, 8, 8), 4'hF, 1'b0};
        v[14] = '{OP_MIN, 4'd15, 4'hF, pk(100, 200, 0, 32'hFFFF_FFFE), pk(99, 201, 0, 32'hFFFF_FFFF), pk(99, 200, 0, 32'hFFFF_FFFE), 4'hF, 1'b0};
        v[15] = '{OP_XNOR, 4'd0, 4'hF, pk(1, 2, 3, 4), pk(1, 2, 3, 4), {128{1'b1}}, 4'hF, 1'b0};

        // reset state
        #1 rst_n = 1'b0;
        #12;
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_result", out_result, '0);
        chk("rst_fields", 128'({out_wr_mask, out_rd, out_illegal}), 128'd0);
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // table, all back-to-back with out_ready=1
        p0 = pops;
        for (int i = 0; i < NV; i++)
            send(v[i].op, v[i].rd, v[i].mask, v[i].a, v[i].b, '{v[i].res, v[i].wm, v[i].ill, v[i].rd});
        drain();
        chk("stream_span", (pop_cyc.size() >= p0 + 16) ? 128'(pop_cyc[p0+15] - pop_cyc[p0+8]) : '1, 128'd7);
        chk("table_span", (pop_cyc.size() >= p0 + 16) ? 128'(pop_cyc[p0+15] - pop_cyc[p0]) : '1, 128'd15);

        // DIV timing: busy over N..N+31, out_valid from N+32
        a = pk(100, 7, 32'hFFFF_FFFF, 9);
        b = pk(7, 0, 1, 10);
        in_valid = 1'b1; in_opcode = OP_DIV; in_rd = 4'd6; in_lane_mask = 4'hF; in_a = a; in_b = b;
        @(negedge clk);
        chk("div_in_ready", 128'(in_ready), 128'd1);
        sb.push_back('{pk(14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0), 4'hF, 1'b0, 4'd6});
        @(posedge clk);
        #1 in_valid = 1'b0;
        in_a = '0; in_b = '0; in_lane_mask = 4'h0;
        chk("div_start", 128'({busy, in_ready, out_valid}), 128'b100);
        ok = 1'b1;
        for (int k = 1; k < 32; k++) begin
            @(posedge clk);
            #1 if (!(busy && !in_ready && !out_valid)) ok = 1'b0;
        end
        chk("div_busy_window", 128'(ok), 128'd1);
        @(posedge clk);
        #1 chk("div_done", 128'({busy, in_ready, out_valid}), 128'b011);
        drain();

        // backpressure on a single-cycle result
        out_ready = 1'b0;
        send(OP_SUB, 4'd9, 4'hF, pk(5, 5, 5, 5), pk(3, 3, 3, 3), '{pk(2, 2, 2, 2), 4'hF, 1'b0, 4'd9});
        chk("bp_valid", 128'(out_valid), 128'd1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_ctl", 128'({out_valid, in_ready}), 128'b10);
            chk("bp_hold_res", out_result, pk(2, 2, 2, 2));
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_same_cycle", 128'(in_ready), 128'd1);
        @(posedge clk);
        #1 chk("bp_consumed", 128'(out_valid), 128'd0);

        // random stream against the reference model, including DIVs
        for (int i = 0; i < 24; i++) begin
            op = opcodes_t'(4'($urandom_range(0, 15)));
            m  = 4'($urandom);
            a  = {$urandom, $urandom, $urandom, $urandom};
            for (int l = 0; l < 4; l++)
                b[l*32 +: 32] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            e = ref_req(op, 4'(i), m, a, b);
            send(op, 4'(i), m, a, b, e);
        end
        drain();

        // reset in the middle of a DIV aborts it silently
        in_valid = 1'b1; in_opcode = OP_DIV; in_rd = 4'd3; in_lane_mask = 4'hF;
        in_a = pk(50, 60, 70, 80); in_b = pk(5, 6, 7, 8);
        @(negedge clk);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 chk("rdiv_busy_before", 128'(busy), 128'd1);
        rst_n = 1'b0;
        #1;
        chk("rdiv_abort", 128'({out_valid, busy}), 128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid || busy) n++;
        end
        chk("rdiv_no_stale", 128'(n), 128'd0);
        chk("rdiv_in_ready", 128'(in_ready), 128'd1);
        chk("rdiv_sb_empty", 128'(sb.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/simd_alu_pipe.md
Name: simd_alu_pipe

Overview:
- Multi-lane, registered successor to the single-lane combinational shader ALU.
- Executes one opcodes_t arithmetic/logic op across LANES lanes in parallel, with valid/ready handshakes on input and output.
- DIV runs as a multi-cycle restoring divider; all other ops complete in one cycle.
- Sits between the register-file read stage and the write-back stage of the mini shader core.

Parameters:
- LANES, 4, number of parallel lanes.
- DATA_W, 32, lane operand/result width (unsigned).
- RD_W, 4, destination-register tag width, passed through unchanged.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request this cycle.
- in_opcode  input  opcodes_t  operation (NOP=0, ADD=1, SUB=2, MUL=3, DIV=4, MIN=5, MAX=6, AND=7, OR=8, XOR=9, XNOR=10; 11..15 are not ALU ops).
- in_rd  input  RD_W  destination tag.
- in_lane_mask  input  LANES  per-lane enable.
- in_a  input  LANES*DATA_W  operand A; lane i occupies bits [i*DATA_W +: DATA_W].
- in_b  input  LANES*DATA_W  operand B, same packing.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_rd  output  RD_W  captured tag.
- out_result  output  LANES*DATA_W  per-lane results.
- out_wr_mask  output  LANES  per-lane register-write enable.
- out_illegal  output  1  opcode was not an ALU op.
- busy  output  1  divider iterating.

Behaviour:
- Reset (async assert, sync release): state=IDLE; out_valid=0, out_result=0, out_wr_mask=0, out_rd=0, out_illegal=0, busy=0; divider counter and internal registers cleared. Reset during DIV aborts the op; nothing is emitted.
- Handshake: in_ready = (state==IDLE) && (!out_valid || out_ready). A request is accepted on an edge where in_valid && in_ready. The output is consumed on an edge where out_valid && out_ready. Output fields are held stable while out_valid && !out_ready.
- States: IDLE, DIV.
  - IDLE + accept of non-DIV op: result is registered at the same edge. out_valid=1 on the next cycle (latency 1). Back-to-back accepts give 1 result/cycle when out_ready=1.
  - IDLE + accept of DIV: operands, tag and mask are latched; go to DIV; busy=1; in_ready=0.
  - DIV: one quotient bit per lane per cycle, for DATA_W cycles (counter DATA_W-1 down to 0). On the edge where the counter reaches 0: load quotients into the output register, out_valid=1, busy=0, return to IDLE. For DIV accepted at edge N, out_valid is high from edge N+DATA_W.
  - DIV is never entered while out_valid=1 && !out_ready, because in_ready gates acceptance.
- Arithmetic, all per lane, unsigned, truncated to DATA_W:
  - ADD, SUB, MUL: wrap modulo 2^DATA_W; MUL keeps the low DATA_W bits.
  - DIV: floor(a/b); b==0 gives all ones.
  - MIN, MAX: unsigned compare; equal operands return a.
  - AND, OR, XOR, XNOR: bitwise.
  - NOP: result 0, out_wr_mask=0, out_illegal=0, but still produces out_valid.
- Opcodes 11..15: result 0, out_wr_mask=0, out_illegal=1, latency 1.
- Lane mask: a disabled lane gets result 0 and out_wr_mask bit 0. The mask is captured at accept and is unaffected by later in_lane_mask changes.
- out_rd always equals the in_rd captured at accept.

Test Plan:
- ADD, all lanes enabled: a={1,0xFFFFFFFF,7,100}, b={2,1,3,50} -> next cycle out_valid=1, result={3,0,10,150}, wr_mask=4'b1111.
- DIV: a={100,7,0xFFFFFFFF,9}, b={7,0,1,10}, out_ready=1, accept at edge N -> busy=1 and in_ready=0 over N..N+31; out_valid at edge N+32; result={14,0xFFFFFFFF,0xFFFFFFFF,0}.
- Backpressure: SUB 5-3 accepted, out_ready=0 for 4 cycles -> out_valid held, result=2 stable, in_ready=0; on out_ready=1 the result is consumed and in_ready=1 in the same cycle.
- Streaming: 8 consecutive MIN/MAX/XNOR requests with out_ready=1 -> 8 results on consecutive cycles; MIN(5,5)=5; XNOR(0,0)=0xFFFFFFFF.
- Mask and illegal: mask=4'b0101 on MUL a=b={3,3,3,3} -> result={9,0,9,0}, wr_mask=0101. Opcode 12 -> out_illegal=1, wr_mask=0.
- Reset mid-DIV: assert rst_n=0 at cycle 10 of a DIV -> out_valid=0 and busy=0 immediately; after release in_ready=1 and no stale result is emitted.
